// File: rtl/lut_div_seq.sv
// Iterative Goldschmidt mantissa divider: q = a/b for normalized Q1.23 mantissas.
// One shared 25x25 multiplier alternates between numerator and denominator updates.
module lut_div_seq #(
  parameter int unsigned ITER = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_a,
  input  logic [23:0] in_b,
  output logic [3:0]  lut_index,
  input  logic [23:0] lut_div,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_q,
  output logic        out_err,
  output logic        busy
);

  localparam int unsigned MW = 24;
  localparam int unsigned NW = 25;
  localparam int unsigned PW = 49;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] ITER_LAST = CW'(ITER);

  typedef enum logic [2:0] {
    IDLE,
    SEED_N,
    SEED_D,
    ITER_N,
    ITER_D,
    DONE
  } state_t;

  state_t        state;
  logic [MW-1:0] a_r;
  logic [MW-1:0] b_r;
  logic [NW-1:0] n_r;
  logic [NW-1:0] d_r;
  logic [CW-1:0] cnt;
  logic          err_r;

  logic [NW-1:0] seed;
  logic [NW-1:0] f;
  logic [NW-1:0] mul_x;
  logic [NW-1:0] mul_y;
  logic [PW-1:0] prod;
  logic [NW-1:0] prod_keep;
  logic [CW-1:0] cnt_inc;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign lut_index = b_r[22:19];

  // Q0.24 seed widened to Q1.24; F = 2 - D wraps naturally in 25 bits.
  assign seed    = {1'b0, lut_div};
  assign f       = ~d_r + NW'(1);
  assign cnt_inc = cnt + CW'(1);

  // Shared multiplier operand mux.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state)
      SEED_N: begin
        mul_x = {a_r, 1'b0};
        mul_y = seed;
      end
      SEED_D: begin
        mul_x = {b_r, 1'b0};
        mul_y = seed;
      end
      ITER_N: begin
        mul_x = n_r;
        mul_y = f;
      end
      ITER_D: begin
        mul_x = d_r;
        mul_y = f;
      end
      default: begin
        mul_x = '0;
        mul_y = '0;
      end
    endcase
  end

  // Q2.48 product; bit 49 is never set (N < 2, F < 2), so only 49 bits are formed.
  assign prod      = PW'(mul_x) * PW'(mul_y);
  assign prod_keep = NW'(prod >> 24);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      n_r       <= '0;
      d_r       <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            cnt   <= '0;
            err_r <= ~(in_a[23] & in_b[23]);
            state <= SEED_N;
          end
        end
        // Unnormalized operands spend one cycle here so the error reply lands one cycle after accept.
        SEED_N: begin
          if (err_r) begin
            out_valid <= 1'b1;
            out_q     <= '0;
            out_err   <= 1'b1;
            state     <= DONE;
          end else begin
            n_r   <= prod_keep;
            state <= SEED_D;
          end
        end
        SEED_D: begin
          d_r   <= prod_keep;
          state <= ITER_N;
        end
        ITER_N: begin
          n_r <= prod_keep;
          cnt <= cnt_inc;
          if (cnt_inc == ITER_LAST) begin
            out_valid <= 1'b1;
            out_q     <= prod_keep[24:1];
            out_err   <= 1'b0;
            state     <= DONE;
          end else begin
            state <= ITER_D;
          end
        end
        ITER_D: begin
          d_r   <= prod_keep;
          state <= ITER_N;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lut_div_seq.md
Name: lut_div_seq

Overview:
- Iterative Goldschmidt mantissa divider controller: computes q = a/b for normalized 24-bit mantissas.
- Drives the external reciprocal-seed LUT (4-bit index in, 24-bit Q0.24 seed out, combinational) and time-multiplexes one 25x25 multiplier between numerator and denominator updates.
- Sits between the FP divide front end (exponent/sign handling) and the result normalizer; valid/ready on both sides.

Parameters:
ITER, 3, number of Goldschmidt refinement iterations; legal range 1..4.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands.
in_a  input  24  dividend mantissa, Q1.23; bit 23 must be 1.
in_b  input  24  divisor mantissa, Q1.23; bit 23 must be 1.
lut_index  output  4  seed LUT index.
lut_div  input  24  seed LUT data, Q0.24 (combinational from lut_index).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_q  output  24  quotient a/b, Q1.23, truncated.
out_err  output  1  operand not normalized; out_q forced to 0.
busy  output  1  state != IDLE.

Behaviour:
- Reset: state IDLE, out_valid=0, out_q=0, out_err=0, busy=0, iteration count=0. in_ready=1 in the first cycle after reset. Reset in any state returns to IDLE next cycle; the in-flight operation is discarded and no out_valid is produced.
- States: IDLE, SEED_N, SEED_D, ITER_N, ITER_D, DONE.
- in_ready = (state==IDLE). Accept = in_valid && in_ready: register a_r, b_r; clear the count.
  - If in_a[23]==0 or in_b[23]==0: go to DONE with out_q=0 and out_err=1.
  - Otherwise go to SEED_N.
- lut_index = b_r[22:19] at all times, so it is stable throughout the operation.
- Arithmetic:
  - N and D are 25-bit Q1.24. Operand extension is {a_r,1'b0}; the seed is {1'b0,lut_div}.
  - Products are 50-bit Q2.48; keep bits [48:24] (truncate, no rounding).
  - F = (2^25 - D) mod 2^25, computed combinationally from the current D.
- SEED_N: N <= a_ext*seed, then go to SEED_D.
- SEED_D: D <= b_ext*seed, then go to ITER_N.
- ITER_N: N <= N*F; count++. If count reaches ITER, go to DONE; otherwise go to ITER_D. The final D update is skipped.
- ITER_D: D <= D*F, using the F value from before the update; go to ITER_N.
- Exactly one multiply per cycle through a single shared multiplier; the operand mux is selected by state.
- DONE:
  - out_valid=1, out_q=N[24:1], out_err=0 (or the error values above).
  - Outputs stay stable while out_ready=0.
  - On out_ready=1, go to IDLE next cycle and drop out_valid.
  - No new operand is accepted in the same cycle.
- Latency: accept edge E0 gives out_valid visible after edge E0+2*ITER+1 (7 for ITER=3). Error path: out_valid after E0+1.
- Invariants:
  - D < 1.0 throughout, since the seed under-estimates 1/b.
  - N < 2.0, so no overflow; no saturation logic is required.
- Accuracy for ITER=3: |out_q - a/b| <= 8 ulp (2^-20). Results must be bit-exact against the team C model using the same truncation rules.

Test Plan:
1. Hold rst=1 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_q=0 and out_err=0 from the first post-reset cycle.
2. a=0x800000, b=0x800000, ITER=3 -> lut_index=0, seeds with 0xF0F0F2; out_valid exactly 7 cycles after accept; out_q in [0x7FFFF8,0x800000]; out_err=0.
3. a=0x800000, b=0xC00000 -> lut_index=8; out_q within 8 ulp of 0x555555. Also a=0xC00000, b=0x800000 -> out_q within 8 ulp of 0xC00000.
4. Hold out_ready=0 for 10 cycles after out_valid -> out_q and out_err stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1. An in_valid held high meanwhile is accepted only in IDLE.
5. b=0x400000 (unnormalized) -> out_valid 1 cycle after accept, out_err=1, out_q=0, lut_index unused; the next normal operation is unaffected.
6. Assert rst during ITER_D of an operation -> IDLE next cycle, no out_valid for the aborted operation. Follow with 10k random normalized pairs for ITER=1..4 -> bit-exact vs C model, latency 2*ITER+1.
